trivium_keystream_gen: RTL and testbench

Trivium keystream generator that feeds the byte-wide FIFO directly upstream. It takes an 80-bit key and 80-bit IV and runs the 1152-round warm-up. It then emits one keystream byte per clock (8 rounds unrolled) as FIFO write strobes. It throttles on the FIFO condition code, so no byte is dropped or duplicated.

---
 rtl/trivium_pkg.sv | 45 ++++
 rtl/trivium_keystream_gen_if.sv | 23 ++
 rtl/trivium_step8.sv | 22 ++
 rtl/trivium_keystream_gen.sv | 80 ++++++++
 tb/tb_trivium_keystream_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/trivium_pkg.sv
// Shared types, constants and the single-round Trivium update used by the
// keystream generator and any later cipher stage.
package trivium_pkg;
  localparam int STATE_W        = 288;
  localparam int BITS_PER_CYCLE = 8;
  localparam int WARMUP_CYCLES  = 144;

  typedef logic [STATE_W-1:0] trivium_state_t;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} fsm_t;

  localparam logic [1:0] FIFO_EMPTY = 2'b00;
  localparam logic [1:0] FIFO_PART  = 2'b10;
  localparam logic [1:0] FIFO_FULL  = 2'b11;

  typedef struct packed {
    trivium_state_t st;
    logic           z;
  } round_t;

  // Bit s(i) of the cipher lives at index i-1.
  function automatic round_t trivium_round(input trivium_state_t s);
    round_t r;
    logic   t1, t2, t3;
    t1   = s[65]  ^ s[92];
    t2   = s[161] ^ s[176];
    t3   = s[242] ^ s[287];
    r.z  = t1 ^ t2 ^ t3;
    t1   = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2   = t2 ^ (s[174] & s[175]) ^ s[263];
    t3   = t3 ^ (s[285] & s[286]) ^ s[68];
    r.st = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return r;
  endfunction

  function automatic trivium_state_t trivium_load(input logic [79:0] key,
                                                  input logic [79:0] iv);
    trivium_state_t s;
    s          = '0;
    s[79:0]    = key;
    s[172:93]  = iv;
    s[287:285] = 3'b111;
    return s;
  endfunction
endpackage

// File: rtl/trivium_keystream_gen_if.sv
// Control/keystream bundle between a Trivium generator and its controller.
interface trivium_keystream_gen_if;
  logic [79:0] key;
  logic [79:0] iv;
  logic        start;
  logic        stop;
  logic [1:0]  fifo_cond;
  logic [7:0]  ks_byte;
  logic        ks_write;
  logic        busy;
  logic        ks_ready;
  logic [31:0] ks_count;

  modport master (
    output key, iv, start, stop, fifo_cond,
    input  ks_byte, ks_write, busy, ks_ready, ks_count
  );

  modport slave (
    input  key, iv, start, stop, fifo_cond,
    output ks_byte, ks_write, busy, ks_ready, ks_count
  );
endinterface

// File: rtl/trivium_step8.sv
// Combinational N-round Trivium advance; z of round k lands in o_z[k].
module trivium_step8
  import trivium_pkg::*;
#(
  parameter int N = BITS_PER_CYCLE
) (
  input  trivium_state_t i_state,
  output trivium_state_t o_state,
  output logic [N-1:0]   o_z
);
  always_comb begin
    round_t w_r;
    o_z    = '0;
    w_r.st = i_state;
    w_r.z  = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_r    = trivium_round(w_r.st);
      o_z[k] = w_r.z;
    end
    o_state = w_r.st;
  end
endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream source: load, 1152-round warm-up, then one byte per clock
// into a downstream FIFO, throttled by the FIFO condition code.
module trivium_keystream_gen
  import trivium_pkg::*;
#(
  parameter int BITS_PER_CYCLE = trivium_pkg::BITS_PER_CYCLE,
  parameter int WARMUP_CYCLES  = trivium_pkg::WARMUP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  trivium_keystream_gen_if.slave  bus
);
  localparam int CNT_W = $clog2(WARMUP_CYCLES + 1);

  fsm_t                r_fsm, w_fsm_nxt;
  trivium_state_t      r_state, w_step_state;
  logic [7:0]          w_z;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_ks_count;
  logic                w_load, w_adv, w_ks_write;

  trivium_step8 #(.N(BITS_PER_CYCLE)) u_step (
    .i_state (r_state),
    .o_state (w_step_state),
    .o_z     (w_z)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  // start beats stop; both force ks_write low for the cycle they are seen.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    w_ks_write = 1'b0;
    if (bus.start) begin
      w_load    = 1'b1;
      w_fsm_nxt = WARMUP;
    end else if (bus.stop) begin
      w_fsm_nxt = IDLE;
    end else begin
      case (r_fsm)
        WARMUP: begin
          w_adv = 1'b1;
          if (r_cnt == CNT_W'(WARMUP_CYCLES - 1)) w_fsm_nxt = RUN;
        end
        RUN: begin
          w_ks_write = (bus.fifo_cond != FIFO_FULL);
          w_adv      = w_ks_write;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= '0;
      r_cnt      <= '0;
      r_ks_count <= '0;
    end else if (w_load) begin
      r_state    <= trivium_load(bus.key, bus.iv);
      r_cnt      <= '0;
      r_ks_count <= '0;
    end else begin
      if (w_adv)              r_state    <= w_step_state;
      if (r_fsm == WARMUP)    r_cnt      <= r_cnt + CNT_W'(1);
      if (w_ks_write)         r_ks_count <= r_ks_count + 32'd1;
    end
  end

  assign bus.ks_byte  = w_z;
  assign bus.ks_write = w_ks_write;
  assign bus.busy     = (r_fsm != IDLE);
  assign bus.ks_ready = (r_fsm == RUN);
  assign bus.ks_count = r_ks_count;
endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen with a bit-level Trivium reference
// feeding an expected-byte queue.
module tb_trivium_keystream_gen;
  import trivium_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trivium_keystream_gen_if bus();
  trivium_keystream_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  logic       use_fifo = 1'b0;
  logic [1:0] drv_cond = FIFO_EMPTY;
  logic [8:0] fifo_cnt = '0;
  int         fifo_ovf = 0;

  // 255-entry FIFO that is never read.
  assign bus.fifo_cond = !use_fifo       ? drv_cond   :
                         (fifo_cnt == 0)   ? FIFO_EMPTY :
                         (fifo_cnt == 255) ? FIFO_FULL  : FIFO_PART;

  always @(posedge clk) begin
    if (bus.start) fifo_cnt <= '0;
    else if (use_fifo && bus.ks_write) begin
      if (fifo_cnt == 255) fifo_ovf <= fifo_ovf + 1;
      else                 fifo_cnt <= fifo_cnt + 9'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Trivium written against the 1-based cipher description.
  task automatic mdl_push(input logic [79:0] k, input logic [79:0] v, input int nbytes);
    logic s [1:288];
    logic t1, t2, t3, z;
    logic [7:0] b;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    b = '0;
    for (int r = 0; r < 1152 + nbytes * 8; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 93; i >= 2; i--)   s[i] = s[i-1];
      s[1] = t3;
      for (int i = 177; i >= 95; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[178] = t2;
      if (r >= 1152) begin
        b[(r - 1152) % 8] = z;
        if ((r - 1152) % 8 == 7) exp_q.push_back(b);
      end
    end
  endtask

  // Caller raises start at a negedge; returns the number of clock edges,
  // counting the load edge, until ks_write is first seen (0 on timeout).
  task automatic wait_run(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.ks_write) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_bytes(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      chk({tag, "_wr"}, 64'(bus.ks_write), 64'd1);
      chk(tag, 64'(bus.ks_byte), 64'(exp_q.pop_front()));
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] held;
    rst = 1'b0;
    bus.key = '0; bus.iv = '0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_write", 64'(bus.ks_write), 64'd0);
    chk("rst_busy",  64'(bus.busy),     64'd0);
    chk("rst_ready", 64'(bus.ks_ready), 64'd0);
    chk("rst_count", 64'(bus.ks_count), 64'd0);
    chk("rst_byte",  64'(bus.ks_byte),  64'd0);
    rst = 1'b1;

    // key=0, iv=0: latency and first 64 bytes
    @(negedge clk);
    bus.key = '0; bus.iv = '0; bus.start = 1'b1;
    mdl_push(80'h0, 80'h0, 80);
    #1;
    chk("start_write", 64'(bus.ks_write), 64'd0);
    wait_run(lat);
    chk("lat_k0",   64'(lat),          64'd145);
    chk("busy_run", 64'(bus.busy),     64'd1);
    chk("rdy_run",  64'(bus.ks_ready), 64'd1);
    check_bytes("ks_k0", 64);
    drv_cond = FIFO_FULL;
    #1;
    chk("count64", 64'(bus.ks_count), 64'd64);

    // FIFO full for 10 clocks, then one write on partial
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      chk("bp_write", 64'(bus.ks_write), 64'd0);
      chk("bp_byte",  64'(bus.ks_byte),  64'(held));
      @(negedge clk);
      #1;
    end
    drv_cond = FIFO_PART;
    #1;
    chk("bp_rel_write", 64'(bus.ks_write), 64'd1);
    chk("bp_rel_byte",  64'(bus.ks_byte),  64'(exp_q.pop_front()));
    @(negedge clk);
    drv_cond = FIFO_FULL;
    #1;
    chk("bp_count", 64'(bus.ks_count), 64'd65);
    exp_q.delete();

    // Real FIFO with no reader
    @(negedge clk);
    drv_cond = FIFO_EMPTY;
    bus.key = 80'h3a5f_0c91_77e2_d4b8_1f60; bus.iv = 80'hc0de_1234_abcd_5678_9abc;
    bus.start = 1'b1; use_fifo = 1'b1;
    wait_run(lat);
    chk("lat_fifo", 64'(lat), 64'd145);
    repeat (300) @(negedge clk);
    #1;
    chk("fifo_writes", 64'(fifo_cnt),     64'd255);
    chk("fifo_count",  64'(bus.ks_count), 64'd255);
    chk("fifo_stall",  64'(bus.ks_write), 64'd0);
    chk("fifo_ovf",    64'(fifo_ovf),     64'd0);
    use_fifo = 1'b0;

    // Restart at warm-up clock 70 with key=1
    @(negedge clk);
    bus.key = '0; bus.iv = '0; bus.start = 1'b1;
    for (int i = 1; i < 70; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    bus.key = 80'h1; bus.start = 1'b1;
    mdl_push(80'h1, 80'h0, 16);
    #1;
    chk("rs_write", 64'(bus.ks_write), 64'd0);
    chk("rs_busy",  64'(bus.busy),     64'd1);
    wait_run(lat);
    chk("lat_k1", 64'(lat), 64'd145);
    check_bytes("ks_k1", 16);
    chk("count_k1", 64'(bus.ks_count), 64'd16);

    // start and stop together in RUN
    bus.start = 1'b1; bus.stop = 1'b1;
    #1;
    chk("ss_write", 64'(bus.ks_write), 64'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    #1;
    chk("ss_busy",  64'(bus.busy),     64'd1);
    chk("ss_ready", 64'(bus.ks_ready), 64'd0);
    chk("ss_count", 64'(bus.ks_count), 64'd0);

    // stop alone: IDLE, state held
    exp_q.delete();
    mdl_push(80'h1, 80'h0, 1);
    for (int i = 0; i < 200 && !bus.ks_ready; i++) begin
      @(negedge clk);
      #1;
    end
    chk("st_pre_byte", 64'(bus.ks_byte), 64'(exp_q[0]));
    bus.stop = 1'b1;
    #1;
    chk("st_write", 64'(bus.ks_write), 64'd0);
    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    chk("st_busy",  64'(bus.busy),     64'd0);
    chk("st_write_idle", 64'(bus.ks_write), 64'd0);
    chk("st_hold",  64'(bus.ks_byte),  64'(exp_q.pop_front()));

    // Reset mid-RUN with ks_write high
    @(negedge clk);
    bus.key = 80'h2; bus.start = 1'b1;
    wait_run(lat);
    chk("pre_rst_write", 64'(bus.ks_write), 64'd1);
    rst = 1'b0;
    #1;
    chk("mrst_write", 64'(bus.ks_write), 64'd0);
    chk("mrst_busy",  64'(bus.busy),     64'd0);
    chk("mrst_count", 64'(bus.ks_count), 64'd0);
    chk("mrst_byte",  64'(bus.ks_byte),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
